// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller.
package fetch_controller_pkg;

    // Fetch sequencing states.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StDrain   = 2'd2,
        StDeliver = 2'd3
    } fetch_state_e;

    localparam int unsigned PC_INCREMENT     = 4;
    localparam int unsigned RESET_PC_DEFAULT = 0;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selector: branch target (base + zero-extended offset) or sequential (base + 4).
module fetch_pc_gen
    import fetch_controller_pkg::*;
#(
    parameter int unsigned PC_SIZE        = 32,
    parameter int unsigned BR_OFFSET_SIZE = 16
) (
    input  logic [PC_SIZE-1:0]        base_i,
    input  logic [BR_OFFSET_SIZE-1:0] br_offset_i,
    input  logic                      br_taken_i,
    output logic [PC_SIZE-1:0]        next_pc_o
);

    logic [PC_SIZE-1:0] target_pc;
    logic [PC_SIZE-1:0] seq_pc;

    // Both sums wrap modulo 2^PC_SIZE.
    assign target_pc = base_i + PC_SIZE'(br_offset_i);
    assign seq_pc    = base_i + PC_SIZE'(PC_INCREMENT);
    assign next_pc_o = br_taken_i ? target_pc : seq_pc;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, runs the req/ack memory handshake, applies
// freeze and branch redirects, and presents {PC, instruction, instValid} to IF/ID.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int unsigned        PC_SIZE        = 32,
    parameter int unsigned        INST_SIZE      = 32,
    parameter int unsigned        BR_OFFSET_SIZE = 16,
    parameter logic [PC_SIZE-1:0] RESET_PC       = PC_SIZE'(RESET_PC_DEFAULT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic                      brTaken,
    input  logic [BR_OFFSET_SIZE-1:0] brOffset,
    output logic                      memReq,
    output logic [PC_SIZE-1:0]        memAddr,
    input  logic                      memAck,
    input  logic [INST_SIZE-1:0]      memData,
    output logic [PC_SIZE-1:0]        PC,
    output logic [INST_SIZE-1:0]      instruction,
    output logic                      instValid
);

    fetch_state_e         state_q, state_d;
    logic [PC_SIZE-1:0]   pc_q, pc_d;
    logic [PC_SIZE-1:0]   tgt_q, tgt_d;
    logic [INST_SIZE-1:0] inst_q, inst_d;
    logic [PC_SIZE-1:0]   gen_base;
    logic [PC_SIZE-1:0]   gen_next;

    // While draining, redirects accumulate on the pending target, not on the PC.
    assign gen_base = (state_q == StDrain) ? tgt_q : pc_q;

    fetch_pc_gen #(
        .PC_SIZE        (PC_SIZE),
        .BR_OFFSET_SIZE (BR_OFFSET_SIZE)
    ) u_pc_gen (
        .base_i      (gen_base),
        .br_offset_i (brOffset),
        .br_taken_i  (brTaken),
        .next_pc_o   (gen_next)
    );

    // The outstanding address is always the PC register; it only moves once memReq drops.
    assign memAddr     = pc_q;
    assign PC          = pc_q;
    assign instruction = inst_q;

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        inst_d    = inst_q;
        memReq    = 1'b0;
        instValid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (brTaken) begin
                    pc_d = gen_next;
                end
                state_d = StReq;
            end
            StReq: begin
                memReq = 1'b1;
                if (memAck && brTaken) begin
                    pc_d    = gen_next;
                    state_d = StIdle;
                end else if (memAck) begin
                    inst_d  = memData;
                    state_d = StDeliver;
                end else if (brTaken) begin
                    tgt_d   = gen_next;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                memReq = 1'b1;
                if (brTaken) begin
                    tgt_d = gen_next;
                end
                if (memAck) begin
                    pc_d    = brTaken ? gen_next : tgt_q;
                    state_d = StIdle;
                end
            end
            StDeliver: begin
                instValid = 1'b1;
                // Branch beats freeze; gen_next already picks target vs sequential.
                if (brTaken || !freeze) begin
                    pc_d    = gen_next;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            inst_q  <= inst_d;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a randomized run
// checked against a transaction-level model of the fetch stream.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        brTaken;
    logic [15:0] brOffset;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memData;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        instValid;

    // Second instance with a high reset PC to exercise sequential wrap.
    logic        freeze2;
    logic        brTaken2;
    logic [15:0] brOffset2;
    logic        memReq2;
    logic [31:0] memAddr2;
    logic        memAck2;
    logic [31:0] memData2;
    logic [31:0] PC2;
    logic [31:0] instruction2;
    logic        instValid2;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    int          mem_cnt = 0;
    bit          force_ack = 1'b0;
    bit          cur_ack;
    logic [31:0] cur_data;
    bit          prev_req = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_req2 = 1'b0;
    logic [31:0] req_q[$];
    logic [31:0] req2_q[$];
    logic [31:0] dpc_q[$];
    logic [31:0] dins_q[$];
    logic [31:0] ack_q[$];
    int          dcyc_q[$];

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .brTaken     (brTaken),
        .brOffset    (brOffset),
        .memReq      (memReq),
        .memAddr     (memAddr),
        .memAck      (memAck),
        .memData     (memData),
        .PC          (PC),
        .instruction (instruction),
        .instValid   (instValid)
    );

    fetch_controller #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze2),
        .brTaken     (brTaken2),
        .brOffset    (brOffset2),
        .memReq      (memReq2),
        .memAddr     (memAddr2),
        .memAck      (memAck2),
        .memData     (memData2),
        .PC          (PC2),
        .instruction (instruction2),
        .instValid   (instValid2)
    );

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hxxxx_xxxx;
    endfunction

    // One clock: memory responder answers after mem_lat request cycles, then log events.
    task automatic drive_cycle(input bit br, input logic [15:0] ofs, input bit frz);
        brTaken  = br;
        brOffset = ofs;
        freeze   = frz;
        cur_ack  = 1'b0;
        if (rst) begin
            mem_cnt = 0;
        end else if (memReq) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                cur_ack = 1'b1;
                mem_cnt = 0;
            end
        end
        cur_data = $urandom;
        memAck   = cur_ack | force_ack;
        memData  = cur_data;
        if (cur_ack) ack_q.push_back(cur_data);
        memAck2  = memReq2;
        memData2 = 32'hA5A5_0000 ^ memAddr2;
        @(posedge clk);
        #1;
        cyc++;
        memAck  = 1'b0;
        brTaken = 1'b0;
        if (memReq && !prev_req) req_q.push_back(memAddr);
        if (memReq2 && !prev_req2) req2_q.push_back(memAddr2);
        if (instValid && !prev_valid) begin
            dpc_q.push_back(PC);
            dins_q.push_back(instruction);
            dcyc_q.push_back(cyc);
        end
        prev_req   = memReq;
        prev_req2  = memReq2;
        prev_valid = instValid;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        force_ack = 1'b0;
        drive_cycle(1'b0, 16'h0, 1'b0);
        drive_cycle(1'b0, 16'h0, 1'b0);
        rst = 1'b0;
        req_q.delete();
        req2_q.delete();
        dpc_q.delete();
        dins_q.delete();
        ack_q.delete();
        dcyc_q.delete();
    endtask

    task automatic wait_valid_pc(input logic [31:0] pc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (instValid && PC == pc) begin
                ok = 1'b1;
                return;
            end
            drive_cycle(1'b0, 16'h0, 1'b0);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (memReq) begin
                ok = 1'b1;
                return;
            end
            drive_cycle(1'b0, 16'h0, 1'b0);
        end
    endtask

    task automatic wait_req_addr(input logic [31:0] addr, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (memReq && memAddr == addr) begin
                ok = 1'b1;
                return;
            end
            drive_cycle(1'b0, 16'h0, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_cycle(1'b0, 16'h0, 1'b0);
        drive_cycle(1'b0, 16'h0, 1'b0);
        checks++;
        if (memReq !== 1'b0 || instValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got req=%b valid=%b expected 0 0", memReq, instValid);
        end
        checks++;
        if (memAddr !== 32'h0 || PC !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: got addr=%h pc=%h expected 0", memAddr, PC);
        end
        checks++;
        if (instruction !== 32'h0) begin
            errors++;
            $display("FAIL reset_inst: got %h expected 0", instruction);
        end
        checks++;
        if (memAddr2 !== 32'hFFFF_FFFC || memReq2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_wrap_pc: got %h req=%b expected fffffffc 0", memAddr2, memReq2);
        end
    endtask

    task automatic test_straight();
        do_reset();
        mem_lat = 1;
        for (int k = 0; k < 9; k++) drive_cycle(1'b0, 16'h0, 1'b0);
        checks++;
        if (req_q.size() != 3 || dpc_q.size() != 3) begin
            errors++;
            $display("FAIL straight_count: got reqs=%0d deliveries=%0d expected 3 3",
                     req_q.size(), dpc_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (qget(req_q, i) !== 32'(i * 4) || qget(dpc_q, i) !== 32'(i * 4)) begin
                errors++;
                $display("FAIL straight_addr %0d: got addr=%h pc=%h expected %h", i,
                         qget(req_q, i), qget(dpc_q, i), 32'(i * 4));
            end
            checks++;
            if (qget(dins_q, i) !== qget(ack_q, i)) begin
                errors++;
                $display("FAIL straight_data %0d: got %h expected %h", i,
                         qget(dins_q, i), qget(ack_q, i));
            end
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (i >= dcyc_q.size() || dcyc_q[i] - dcyc_q[i-1] != 3) begin
                errors++;
                $display("FAIL straight_period %0d: got %0d expected 3", i,
                         (i < dcyc_q.size()) ? dcyc_q[i] - dcyc_q[i-1] : -1);
            end
        end
    endtask

    task automatic test_freeze();
        bit          ok;
        logic [31:0] held;
        do_reset();
        mem_lat = 3;
        wait_valid_pc(32'h8, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL freeze_reach: got no delivery expected pc 00000008");
        end
        held = instruction;
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b0, 16'h0, 1'b1);
            checks++;
            if (instValid !== 1'b1 || PC !== 32'h8 || instruction !== held) begin
                errors++;
                $display("FAIL freeze_hold %0d: got valid=%b pc=%h inst=%h expected 1 8 %h",
                         k, instValid, PC, instruction, held);
            end
        end
        drive_cycle(1'b0, 16'h0, 1'b0);
        checks++;
        if (instValid !== 1'b0 || memReq !== 1'b0) begin
            errors++;
            $display("FAIL freeze_release: got valid=%b req=%b expected 0 0", instValid, memReq);
        end
        wait_req(ok);
        checks++;
        if (!ok || memAddr !== 32'hC) begin
            errors++;
            $display("FAIL freeze_next: got %h expected 0000000c", memAddr);
        end
        checks++;
        if (req_q.size() != 4 || qget(req_q, 2) !== 32'h8 || dpc_q.size() != 3) begin
            errors++;
            $display("FAIL freeze_stream: got reqs=%0d deliveries=%0d expected 4 3",
                     req_q.size(), dpc_q.size());
        end
    endtask

    task automatic test_br_deliver();
        bit ok;
        do_reset();
        mem_lat = 1;
        wait_valid_pc(32'h4, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL brdel_reach: got no delivery expected pc 00000004");
        end
        drive_cycle(1'b1, 16'h20, 1'b1);
        checks++;
        if (instValid !== 1'b0) begin
            errors++;
            $display("FAIL brdel_drop: got valid=%b expected 0", instValid);
        end
        wait_req(ok);
        checks++;
        if (!ok || memAddr !== 32'h24) begin
            errors++;
            $display("FAIL brdel_target: got %h expected 00000024", memAddr);
        end
    endtask

    task automatic test_br_drain();
        bit ok;
        int ndel;
        do_reset();
        mem_lat = 4;
        wait_req_addr(32'h8, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_reach: got no request expected addr 00000008");
        end
        ndel = dpc_q.size();
        drive_cycle(1'b0, 16'h0, 1'b0);
        drive_cycle(1'b1, 16'h10, 1'b0);
        for (int k = 0; k < 20 && memReq; k++) begin
            checks++;
            if (memAddr !== 32'h8 || instValid !== 1'b0) begin
                errors++;
                $display("FAIL drain_hold: got addr=%h valid=%b expected 8 0", memAddr, instValid);
            end
            drive_cycle(1'b0, 16'h0, 1'b0);
        end
        checks++;
        if (memReq !== 1'b0 || dpc_q.size() != ndel) begin
            errors++;
            $display("FAIL drain_done: got req=%b deliveries=%0d expected 0 %0d",
                     memReq, dpc_q.size(), ndel);
        end
        wait_req(ok);
        checks++;
        if (!ok || memAddr !== 32'h18) begin
            errors++;
            $display("FAIL drain_target: got %h expected 00000018", memAddr);
        end
    endtask

    task automatic test_br_ack();
        do_reset();
        mem_lat = 1;
        drive_cycle(1'b1, 16'h100, 1'b0);
        checks++;
        if (memReq !== 1'b1 || memAddr !== 32'h100) begin
            errors++;
            $display("FAIL brack_setup: got req=%b addr=%h expected 1 00000100", memReq, memAddr);
        end
        drive_cycle(1'b1, 16'h8, 1'b0);
        checks++;
        if (memReq !== 1'b0 || instValid !== 1'b0) begin
            errors++;
            $display("FAIL brack_idle: got req=%b valid=%b expected 0 0", memReq, instValid);
        end
        drive_cycle(1'b0, 16'h0, 1'b0);
        checks++;
        if (memReq !== 1'b1 || memAddr !== 32'h108 || dpc_q.size() != 0) begin
            errors++;
            $display("FAIL brack_next: got req=%b addr=%h del=%0d expected 1 00000108 0",
                     memReq, memAddr, dpc_q.size());
        end
    endtask

    task automatic test_reset_drain();
        bit ok;
        do_reset();
        mem_lat = 1;
        wait_valid_pc(32'h4, ok);
        mem_lat = 10;
        wait_req_addr(32'h8, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstdrain_reach: got no request expected addr 00000008");
        end
        drive_cycle(1'b1, 16'h40, 1'b0);
        rst = 1'b1;
        drive_cycle(1'b0, 16'h0, 1'b0);
        checks++;
        if (memReq !== 1'b0 || instValid !== 1'b0 || memAddr !== 32'h0 || PC !== 32'h0 ||
            instruction !== 32'h0) begin
            errors++;
            $display("FAIL rstdrain_outputs: got req=%b valid=%b addr=%h inst=%h expected 0 0 0 0",
                     memReq, instValid, memAddr, instruction);
        end
        rst       = 1'b0;
        force_ack = 1'b1;
        drive_cycle(1'b0, 16'h0, 1'b0);
        force_ack = 1'b0;
        checks++;
        if (memReq !== 1'b1 || memAddr !== 32'h0 || instValid !== 1'b0) begin
            errors++;
            $display("FAIL rstdrain_spurious: got req=%b addr=%h valid=%b expected 1 0 0",
                     memReq, memAddr, instValid);
        end
        mem_lat = 1;
        drive_cycle(1'b0, 16'h0, 1'b0);
        checks++;
        if (instValid !== 1'b1 || PC !== 32'h0) begin
            errors++;
            $display("FAIL rstdrain_first: got valid=%b pc=%h expected 1 0", instValid, PC);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr[3];
        exp_addr[0] = 32'hFFFF_FFFC;
        exp_addr[1] = 32'h0;
        exp_addr[2] = 32'h4;
        do_reset();
        for (int k = 0; k < 8; k++) drive_cycle(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (qget(req2_q, i) !== exp_addr[i]) begin
                errors++;
                $display("FAIL wrap_addr %0d: got %h expected %h", i, qget(req2_q, i),
                         exp_addr[i]);
            end
        end
    endtask

    // Model: target accumulates every redirect; a fetch is delivered only if no redirect
    // arrived between its request and its ack; leaving a delivery unredirected adds 4.
    task automatic test_random();
        bit          br;
        bit          frz;
        logic [15:0] ofs;
        int          phase;
        bit          redir;
        logic [31:0] target;
        logic [31:0] m_addr;
        logic [31:0] m_instr;
        do_reset();
        mem_lat = $urandom_range(1, 4);
        phase   = 0;
        redir   = 1'b0;
        target  = 32'h0;
        m_addr  = 32'h0;
        m_instr = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            checks++;
            if (memReq !== 1'(phase == 1) || instValid !== 1'(phase == 2)) begin
                errors++;
                $display("FAIL rand_ctrl cyc %0d: got req=%b valid=%b expected req=%b valid=%b",
                         n, memReq, instValid, phase == 1, phase == 2);
            end
            if (phase == 1) begin
                checks++;
                if (memAddr !== m_addr) begin
                    errors++;
                    $display("FAIL rand_addr cyc %0d: got %h expected %h", n, memAddr, m_addr);
                end
            end
            if (phase == 2) begin
                checks++;
                if (PC !== m_addr || instruction !== m_instr) begin
                    errors++;
                    $display("FAIL rand_deliver cyc %0d: got pc=%h inst=%h expected %h %h",
                             n, PC, instruction, m_addr, m_instr);
                end
            end
            br  = ($urandom_range(0, 7) == 0);
            ofs = 16'($urandom);
            frz = ($urandom_range(0, 2) == 0);
            drive_cycle(br, ofs, frz);
            if (cur_ack) mem_lat = $urandom_range(1, 4);
            if (br) target = target + 32'(ofs);
            case (phase)
                0: begin
                    m_addr = target;
                    redir  = 1'b0;
                    phase  = 1;
                end
                1: begin
                    if (br) redir = 1'b1;
                    if (cur_ack) begin
                        if (redir) begin
                            phase = 0;
                        end else begin
                            m_instr = cur_data;
                            phase   = 2;
                        end
                    end
                end
                default: begin
                    if (br) begin
                        phase = 0;
                    end else if (!frz) begin
                        target = target + 32'd4;
                        phase  = 0;
                    end
                end
            endcase
        end
    endtask

    initial begin
        rst       = 1'b1;
        freeze    = 1'b0;
        brTaken   = 1'b0;
        brOffset  = 16'h0;
        memAck    = 1'b0;
        memData   = 32'h0;
        freeze2   = 1'b0;
        brTaken2  = 1'b0;
        brOffset2 = 16'h0;
        memAck2   = 1'b0;
        memData2  = 32'h0;
        test_reset();
        test_straight();
        test_freeze();
        test_br_deliver();
        test_br_drain();
        test_br_ack();
        test_reset_drain();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
